rst_seq_gen: RTL and testbench
==============================

# rst_seq_gen

Parametrised, synthesisable reset sequencer and clock-enable generator for multi-channel stream benches and FPGA wrappers. From one clock and one global reset it produces NUM_CH per-channel resets, released in a fixed staggered order. It also produces optional per-channel divided clock-enable strobes. Software can request a full re-sequence at runtime through a req/ack handshake.

## Interface
- NUM_CH, default 4: number of reset channels, at least 1.
- CNT_W, default 16: width of the hold, stagger and divider counters.
- HOLD_CYCLES, default 8: cycles all channels stay in reset after rst_i drops; at least 1.
- STAGGER, default 4: cycles between consecutive channel releases; at least 1.
- DIV_RATIO, default 2: base divider. Channel k enable period is (k+1)*DIV_RATIO cycles; must be at least 1.
- clk_i  in  1  the single clock. All logic is on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- sw_rst_req_i  in  1  soft re-sequence request, level.
- sw_rst_ack_o  out  1  one-cycle pulse when a soft re-sequence completes.
- rst_o  out  NUM_CH  per-channel resets, active-high.
- all_rdy_o  out  1  high while all channels are released.
- busy_o  out  1  high while a sequence is in progress.
- clk_en_o  out  NUM_CH  per-channel clock-enable strobes.

## Operation
- FSM states:
  - ASSERT: all rst_o high; counter runs 0..HOLD_CYCLES-1.
  - RELEASE: counter runs 0..STAGGER-1; channel index idx advances.
  - RUN: all rst_o low.
- ASSERT exit: at cnt==HOLD_CYCLES-1, rst_o[0] drops on the next edge. State goes to RELEASE with idx=1, or to RUN if NUM_CH==1.
- RELEASE: at cnt==STAGGER-1, rst_o[idx] drops and idx increments. Releasing NUM_CH-1 moves the FSM to RUN.
- Release order is fixed: channel 0 first. A released channel is never re-asserted except by rst_i or a soft re-sequence.
- Soft request: sw_rst_req_i sets the pending flag in any state, on any cycle it is high.
  - In RUN with pending set, the FSM enters ASSERT and all rst_o go high on the next edge.
  - On the edge that re-enters RUN after a pending-triggered sequence, sw_rst_ack_o pulses for one cycle and pending clears.
  - The requester must drop req in the ack cycle. If req is still high, pending is set again and another sequence follows.
  - A request made during ASSERT or RELEASE does not restart the current sequence. It is serviced after RUN is reached, so that sequence completes and is immediately followed by a full new one.
- rst_i has priority over everything. It aborts any state, clears pending and idx, and suppresses ack.
- busy_o = (state != RUN). all_rdy_o = (state == RUN).

## Timing
- Reset values, while rst_i is high and for the first edge after it: rst_o all ones, all_rdy_o 0, busy_o 1, sw_rst_ack_o 0, clk_en_o all zeros, state ASSERT, counters 0.
- With rst_i low from edge E0, rst_o[k] falls at edge E0 + HOLD_CYCLES + k*STAGGER.
- all_rdy_o rises on the same edge as rst_o[NUM_CH-1] falls.
- Soft re-sequence seen in RUN at edge S:
  - rst_o goes all ones at S+1.
  - The release schedule above then runs with E0 = S+1.
- rst_i asserted mid-sequence: at the next edge all rst_o return high and counters restart.

## Configuration
- Macro RST_SEQ_GEN_CLKEN_EN.
- Defined: each channel has a divider counter. The counter is held at 0 while rst_o[k] is high and counts from the release edge. clk_en_o[k] is high for one cycle when the counter equals (k+1)*DIV_RATIO-1, then the counter wraps to 0. The first strobe is (k+1)*DIV_RATIO cycles after release.
- Undefined: divider logic is not compiled. clk_en_o is tied to all ones; the port remains.

## Structure
- Shared package rst_seq_pkg holds:
  - the state enum type (ASSERT, RELEASE, RUN);
  - a helper function computing the channel-k divider period.
- One sub-module, rst_seq_clken_div: a single-channel divider instantiated NUM_CH times in a generate loop, only under the macro.

## Test plan
- Power-on, defaults: rst_i high for 5 cycles, then low at E0. Required: rst_o falls in order at E0+8, +12, +16, +20; all_rdy_o rises at E0+20; busy_o falls at E0+20.
- Soft request in RUN: req at edge S, dropped on ack. Required: rst_o=4'hF at S+1; ack is a single pulse at S+21; all_rdy_o high again at S+21.
- Request during RELEASE, held 1 cycle: the current sequence completes. Required: a second full 20-cycle sequence starts the cycle after RUN is entered; exactly one ack pulse.
- rst_i pulsed at E0+14, mid-RELEASE: rst_o[1:0] re-assert at the next edge. Required: the schedule restarts from the new E0; no ack.
- Macro defined: after release, clk_en_o[0] strobes every 2 cycles and clk_en_o[3] every 8 cycles. The first clk_en_o[3] strobe is 8 cycles after rst_o[3] falls.
- NUM_CH=1, HOLD_CYCLES=1, STAGGER=1: rst_o falls at E0+1 and all_rdy_o rises at E0+1; the FSM never enters RELEASE.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } seq_state_e;

  // Clock-enable period of channel ch: (ch+1) * base divider.
  function automatic int unsigned ch_div_period(input int unsigned ch,
                                                input int unsigned div_ratio);
    return (ch + 1) * div_ratio;
  endfunction

endpackage

// File: rtl/rst_seq_clken_div.sv
// Single-channel clock-enable divider. Held at zero while the channel is in
// reset; strobes for one cycle every PERIOD cycles once released.
module rst_seq_clken_div #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PERIOD = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ch_rst_i,
  output logic clk_en_o
);

  localparam logic [CNT_W-1:0] Last = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             en_q;

  // Count from the release edge; strobe and wrap at the end of each period.
  always_ff @(posedge clk_i) begin
    if (rst_i || ch_rst_i) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (cnt_q == Last) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      en_q  <= 1'b0;
    end
  end

  assign clk_en_o = en_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Staggered multi-channel reset sequencer with soft re-sequence handshake.
// Optional per-channel divided clock enables under RST_SEQ_GEN_CLKEN_EN;
// without it clk_en_o is tied high.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned DIV_RATIO   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sw_rst_req_i,
  output logic              sw_rst_ack_o,
  output logic [NUM_CH-1:0] rst_o,
  output logic              all_rdy_o,
  output logic              busy_o,
  output logic [NUM_CH-1:0] clk_en_o
);

  localparam int unsigned      IdxW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] StagLast  = CNT_W'(STAGGER - 1);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_CH - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [NUM_CH-1:0] rst_q;
  logic             pending_q;
  logic             soft_q;   // current sequence was started by a soft request
  logic             ack_q;

  // Sequencer FSM. Channels are released low-to-high, so each release is a
  // left shift of the reset vector. Later pending_q writes override the
  // request capture, giving the ack edge priority over a still-high request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StAssert;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_q     <= '1;
      pending_q <= 1'b0;
      soft_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (sw_rst_req_i) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            rst_q <= rst_q << 1;
            cnt_q <= '0;
            if (NUM_CH == 1) begin
              state_q <= StRun;
              if (soft_q) begin
                ack_q     <= 1'b1;
                pending_q <= 1'b0;
                soft_q    <= 1'b0;
              end
            end else begin
              state_q <= StRelease;
              idx_q   <= IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRelease: begin
          if (cnt_q == StagLast) begin
            rst_q <= rst_q << 1;
            cnt_q <= '0;
            if (idx_q == IdxLast) begin
              state_q <= StRun;
              if (soft_q) begin
                ack_q     <= 1'b1;
                pending_q <= 1'b0;
                soft_q    <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          if (pending_q) begin
            state_q <= StAssert;
            rst_q   <= '1;
            cnt_q   <= '0;
            idx_q   <= '0;
            soft_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StAssert;
          rst_q   <= '1;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign rst_o        = rst_q;
  assign sw_rst_ack_o = ack_q;
  assign all_rdy_o    = (state_q == StRun);
  assign busy_o       = (state_q != StRun);

`ifdef RST_SEQ_GEN_CLKEN_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_div
    rst_seq_clken_div #(
      .CNT_W  (CNT_W),
      .PERIOD (ch_div_period(k, DIV_RATIO))
    ) u_div (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .ch_rst_i (rst_q[k]),
      .clk_en_o (clk_en_o[k])
    );
  end
`else
  assign clk_en_o = '1;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default 4-channel instance plus a
// single-channel, minimum-timing instance.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst, rst1, req;
  logic       ack, rdy, busy;
  logic [3:0] rst_o, clk_en;
  logic       ack1, rdy1, busy1;
  logic [0:0] rst1_o, clk_en1;

  int n_chk = 0;
  int n_err = 0;
  int ecnt = 0;
  int ack_cnt = 0;
  int ack1_cnt = 0;
  int last_ack = -1;
  int e0, e1, s;

  always #5 clk = ~clk;

  rst_seq_gen u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sw_rst_req_i (req),
    .sw_rst_ack_o (ack),
    .rst_o        (rst_o),
    .all_rdy_o    (rdy),
    .busy_o       (busy),
    .clk_en_o     (clk_en)
  );

  rst_seq_gen #(
    .NUM_CH      (1),
    .HOLD_CYCLES (1),
    .STAGGER     (1)
  ) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst1),
    .sw_rst_req_i (1'b0),
    .sw_rst_ack_o (ack1),
    .rst_o        (rst1_o),
    .all_rdy_o    (rdy1),
    .busy_o       (busy1),
    .clk_en_o     (clk_en1)
  );

  typedef struct {
    int         off;
    logic [3:0] rst;
    logic       rdy;
    logic       busy;
    logic       rst1;
    logic       rdy1;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (ack === 1'b1) begin
      ack_cnt++;
      last_ack = ecnt;
    end
    if (ack1 === 1'b1) ack1_cnt++;
  endtask

  task automatic wait_until(input int target);
    while (ecnt < target) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got %0h, want %0h", name, ecnt, act, exp);
    end
  endtask

`ifdef RST_SEQ_GEN_CLKEN_EN
  localparam logic [3:0] EnRst = 4'h0;
`else
  localparam logic [3:0] EnRst = 4'hF;
`endif

  initial begin
    // Power-on schedule, offsets from E0 (last edge with rst high).
    tbl[0]  = '{0,  4'hF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,  4'hF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{7,  4'hF, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{8,  4'hE, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{11, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{12, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{15, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{16, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{19, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{20, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{21, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{30, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst  = 1'b1;
    rst1 = 1'b1;
    req  = 1'b0;
    repeat (5) tick();
    e0 = ecnt;
    chk("por_ack", 32'(ack), 32'h0);
    chk("por_clken", 32'(clk_en), 32'(EnRst));
    rst  = 1'b0;
    rst1 = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wait_until(e0 + tbl[i].off);
      chk("por_rst", 32'(rst_o), 32'(tbl[i].rst));
      chk("por_rdy", 32'(rdy), 32'(tbl[i].rdy));
      chk("por_busy", 32'(busy), 32'(tbl[i].busy));
      chk("ch1_rst", 32'(rst1_o), 32'(tbl[i].rst1));
      chk("ch1_rdy", 32'(rdy1), 32'(tbl[i].rdy1));
    end
    chk("por_no_ack", 32'(ack_cnt), 32'h0);

    // Soft re-sequence from RUN; requester drops req when it sees ack.
    ack_cnt = 0;
    req = 1'b1;
    s = ecnt + 1;
    while (ecnt < s + 30) begin
      tick();
      if (ack === 1'b1) req = 1'b0;
      if (ecnt == s)      chk("soft_s_rst", 32'(rst_o), 32'h0);
      if (ecnt == s + 1)  chk("soft_assert", 32'(rst_o), 32'hF);
      if (ecnt == s + 9)  chk("soft_ch0", 32'(rst_o), 32'hE);
      if (ecnt == s + 21) chk("soft_rdy", 32'(rdy), 32'h1);
    end
    req = 1'b0;
    chk("soft_ack_cnt", 32'(ack_cnt), 32'h1);
    chk("soft_ack_at", 32'(last_ack), 32'(s + 21));
    chk("soft_settled", 32'(rst_o), 32'h0);

    // Request during RELEASE of a rst_i-started sequence.
    rst = 1'b1;
    tick();
    tick();
    e0 = ecnt;
    rst = 1'b0;
    ack_cnt = 0;
    wait_until(e0 + 10);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("rel_req_rst", 32'(rst_o), 32'hE);
    wait_until(e0 + 20);
    chk("rel_first_rdy", 32'(rdy), 32'h1);
    chk("rel_first_noack", 32'(ack_cnt), 32'h0);
    wait_until(e0 + 21);
    chk("rel_second_rst", 32'(rst_o), 32'hF);
    chk("rel_second_busy", 32'(busy), 32'h1);
    wait_until(e0 + 29);
    chk("rel_second_ch0", 32'(rst_o), 32'hE);
    wait_until(e0 + 41);
    chk("rel_second_done", 32'(rst_o), 32'h0);
    chk("rel_ack_at", 32'(last_ack), 32'(e0 + 41));
    wait_until(e0 + 48);
    chk("rel_ack_cnt", 32'(ack_cnt), 32'h1);
    chk("rel_stay_rdy", 32'(rdy), 32'h1);

    // rst_i pulse mid-RELEASE.
    rst = 1'b1;
    tick();
    e0 = ecnt;
    rst = 1'b0;
    ack_cnt = 0;
    wait_until(e0 + 13);
    chk("abort_before", 32'(rst_o), 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e1 = ecnt;
    chk("abort_rst", 32'(rst_o), 32'hF);
    chk("abort_rdy", 32'(rdy), 32'h0);
    chk("abort_clken", 32'(clk_en), 32'(EnRst));
    wait_until(e1 + 7);
    chk("abort_hold", 32'(rst_o), 32'hF);
    wait_until(e1 + 8);
    chk("abort_ch0", 32'(rst_o), 32'hE);
`ifdef RST_SEQ_GEN_CLKEN_EN
    wait_until(e1 + 9);
    chk("en0_p9", 32'(clk_en[0]), 32'h0);
    wait_until(e1 + 10);
    chk("en0_p10", 32'(clk_en[0]), 32'h1);
    wait_until(e1 + 11);
    chk("en0_p11", 32'(clk_en[0]), 32'h0);
    wait_until(e1 + 12);
    chk("en0_p12", 32'(clk_en[0]), 32'h1);
`else
    wait_until(e1 + 10);
    chk("en_tied", 32'(clk_en), 32'hF);
`endif
    wait_until(e1 + 20);
    chk("abort_done", 32'(rst_o), 32'h0);
    chk("abort_rdy_end", 32'(rdy), 32'h1);
`ifdef RST_SEQ_GEN_CLKEN_EN
    chk("en3_rel", 32'(clk_en[3]), 32'h0);
    wait_until(e1 + 27);
    chk("en3_p27", 32'(clk_en[3]), 32'h0);
    wait_until(e1 + 28);
    chk("en3_p28", 32'(clk_en[3]), 32'h1);
    wait_until(e1 + 29);
    chk("en3_p29", 32'(clk_en[3]), 32'h0);
    wait_until(e1 + 35);
    chk("en3_p35", 32'(clk_en[3]), 32'h0);
    wait_until(e1 + 36);
    chk("en3_p36", 32'(clk_en[3]), 32'h1);
`else
    wait_until(e1 + 28);
    chk("en_tied_run", 32'(clk_en), 32'hF);
`endif
    chk("abort_no_ack", 32'(ack_cnt), 32'h0);
    chk("ch1_no_ack", 32'(ack1_cnt), 32'h0);
    chk("ch1_busy", 32'(busy1), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
